// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: row strobing, whole-frame debounce, single-key events with valid/ack.
// Optional auto-repeat of a held single key is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
  parameter int unsigned SCAN_PERIOD = 1000,
  parameter int unsigned DEBOUNCE    = 20
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 125,
  parameter int unsigned REPEAT_FRAMES = 25
`endif
) (
  input  logic       clkus,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       key_multi,
  output logic       key_overrun
);

  localparam int unsigned SLOT_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 16; i++) s = s + 5'(v[i]);
    return s;
  endfunction

  // Lowest set bit; only used on vectors holding exactly one key.
  function automatic logic [3:0] first_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        row_idx;
  logic [15:0]       snapshot, prev_snap, debounced;
  logic [CNT_W-1:0]  stable_cnt;

  logic        slot_last, frame_end, same, commit, press_evt, evt;
  logic [15:0] snap_next;
  logic [4:0]  new_pop, old_pop;
  logic [3:0]  evt_code;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_FRAMES) ? REPEAT_DELAY : REPEAT_FRAMES;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  logic [REP_W-1:0] rep_cnt;
  logic             rep_armed, repeat_evt;
`endif

  always_comb begin
    slot_last = (slot_cnt == SLOT_W'(SCAN_PERIOD - 1));
    frame_end = slot_last && (row_idx == 2'd3);
    snap_next = snapshot;
    if (slot_last) snap_next[{row_idx, 2'b00} +: 4] = ~col;
    same      = (snap_next == prev_snap);
    commit    = frame_end && same && (stable_cnt == CNT_W'(DEBOUNCE - 1));
    new_pop   = popcnt(snap_next);
    old_pop   = popcnt(debounced);
    press_evt = commit && (old_pop == 5'd0) && (new_pop == 5'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
    // First repeat after REPEAT_DELAY frames, then every REPEAT_FRAMES.
    repeat_evt = frame_end && !commit && (old_pop == 5'd1) &&
                 (rep_armed ? (rep_cnt == REP_W'(REPEAT_FRAMES - 1))
                            : (rep_cnt == REP_W'(REPEAT_DELAY - 1)));
    evt        = press_evt || repeat_evt;
    evt_code   = press_evt ? first_idx(snap_next) : first_idx(debounced);
`else
    evt        = press_evt;
    evt_code   = first_idx(snap_next);
`endif
  end

  // Scan, debounce and commit.
  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      slot_cnt   <= '0;
      row_idx    <= 2'd0;
      row        <= 4'b1110;
      snapshot   <= '0;
      prev_snap  <= '0;
      debounced  <= '0;
      stable_cnt <= '0;
      key_held   <= 1'b0;
      key_multi  <= 1'b0;
    end else begin
      snapshot <= snap_next;
      if (slot_last) begin
        slot_cnt <= '0;
        row_idx  <= 2'(row_idx + 2'd1);
        row      <= {row[2:0], row[3]};
      end else begin
        slot_cnt <= SLOT_W'(slot_cnt + 1'b1);
      end
      if (frame_end) begin
        prev_snap <= snap_next;
        if (!same) stable_cnt <= '0;
        else if (stable_cnt != CNT_W'(DEBOUNCE)) stable_cnt <= CNT_W'(stable_cnt + 1'b1);
      end
      if (commit) begin
        debounced <= snap_next;
        key_held  <= (new_pop != 5'd0);
        key_multi <= (new_pop >= 5'd2);
      end
    end
  end

  // Core handshake: a new event always wins over a simultaneous ack.
  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      key_code    <= 4'd0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else if (evt) begin
      key_valid <= 1'b1;
      key_code  <= evt_code;
      if (key_valid && !key_ack) key_overrun <= 1'b1;
      else if (key_ack)          key_overrun <= 1'b0;
    end else if (key_ack) begin
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clkus or posedge rst) begin
    if (rst) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (commit) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (repeat_evt) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b1;
    end else if (frame_end && (old_pop == 5'd1)) begin
      rep_cnt <= REP_W'(rep_cnt + 1'b1);
    end
  end
`endif

endmodule
